id_ex_cond_stage: RTL and testbench

Decode-to-execute pipeline boundary of the pipelined core. It latches the decoder's control word and operands into the execute stage and holds the architectural NZCV flag register. Each cycle it evaluates the instruction's condition code against those flags and gates the instruction's side-effecting controls (`PCSrc`, `RegWrite`, `MemWrite`, `Branch`, flag writes) before they reach execute/memory. Stall and flush inputs come from the hazard unit.

---
 rtl/id_ex_cond_stage.sv | 189 ++++++++++++++++++
 tb/tb_id_ex_cond_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_cond_stage.sv
// id_ex_cond_stage: decode-to-execute pipeline register with the NZCV flag register and
// condition-code gating of the side-effecting controls.
//
// Build option: define COND_EXEC_EN to enable full condition-code evaluation. When it is
// undefined, every valid instruction executes and writes flags unconditionally.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   StallE, FlushE       hazard unit: hold / bubble the E slot (flush wins)
//   *D                   decoder controls, condition, operands, destination
//   ALUFlags             {N,Z,C,V} from the execute ALU for the current E instruction
//   *E                   registered E-stage fields; PCSrcE/RegWriteE/MemWriteE/BranchE gated
//   CondExE              E instruction is valid and its condition holds
//   FlagsE               architectural flag register {N,Z,C,V}
//   ValidE               E slot holds a real instruction
module id_ex_cond_stage #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             PCSrcD,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             MemWriteD,
    input  logic             BranchD,
    input  logic             ALUSrcD,
    input  logic             ALUSelD,
    input  logic [2:0]       ALUControlD,
    input  logic [1:0]       FlagWriteD,
    input  logic [3:0]       CondD,
    input  logic [WIDTH-1:0] RD1D,
    input  logic [WIDTH-1:0] RD2D,
    input  logic [WIDTH-1:0] ExtImmD,
    input  logic [3:0]       WA3D,
    input  logic [3:0]       ALUFlags,
    output logic [2:0]       ALUControlE,
    output logic             ALUSelE,
    output logic             ALUSrcE,
    output logic             MemtoRegE,
    output logic [WIDTH-1:0] RD1E,
    output logic [WIDTH-1:0] RD2E,
    output logic [WIDTH-1:0] ExtImmE,
    output logic [3:0]       WA3E,
    output logic             PCSrcE,
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic             BranchE,
    output logic             CondExE,
    output logic [3:0]       FlagsE,
    output logic             ValidE
);

    // Control bits packed {PCSrc, RegWrite, MemtoReg, MemWrite, Branch, ALUSrc, ALUSel}
    logic [6:0]       ctrl_d, ctrl_q;
    logic [2:0]       alu_ctrl_d, alu_ctrl_q;
    logic [1:0]       flag_wr_d, flag_wr_q;
    logic [3:0]       cond_d, cond_q;
    logic [WIDTH-1:0] rd1_d, rd1_q;
    logic [WIDTH-1:0] rd2_d, rd2_q;
    logic [WIDTH-1:0] imm_d, imm_q;
    logic [3:0]       wa3_d, wa3_q;
    logic             valid_d, valid_q;
    logic [3:0]       flags_d, flags_q;

    logic             cond_ok;
    logic             cond_ex;
    logic             flag_upd;

    logic n_f, z_f, c_f, v_f;
    assign {n_f, z_f, c_f, v_f} = flags_q;

`ifdef COND_EXEC_EN
    always_comb begin
        cond_ok = 1'b0;
        unique case (cond_q)
            4'b0000: cond_ok = z_f;
            4'b0001: cond_ok = !z_f;
            4'b0010: cond_ok = c_f;
            4'b0011: cond_ok = !c_f;
            4'b0100: cond_ok = n_f;
            4'b0101: cond_ok = !n_f;
            4'b0110: cond_ok = v_f;
            4'b0111: cond_ok = !v_f;
            4'b1000: cond_ok = c_f && !z_f;
            4'b1001: cond_ok = !c_f || z_f;
            4'b1010: cond_ok = (n_f == v_f);
            4'b1011: cond_ok = (n_f != v_f);
            4'b1100: cond_ok = !z_f && (n_f == v_f);
            4'b1101: cond_ok = z_f || (n_f != v_f);
            4'b1110: cond_ok = 1'b1;
            4'b1111: cond_ok = 1'b0;
        endcase
    end
`else
    assign cond_ok = 1'b1;
    // Condition and flag values are carried but not consulted in this build.
    logic unused_cond;
    assign unused_cond = ^{cond_q, flags_q};
`endif

    // Bubbles never execute; a stalled instruction must not write flags twice on replay.
    assign cond_ex  = valid_q && cond_ok;
    assign flag_upd = cond_ex && !StallE;

    always_comb begin
        ctrl_d     = ctrl_q;
        alu_ctrl_d = alu_ctrl_q;
        flag_wr_d  = flag_wr_q;
        cond_d     = cond_q;
        rd1_d      = rd1_q;
        rd2_d      = rd2_q;
        imm_d      = imm_q;
        wa3_d      = wa3_q;
        valid_d    = valid_q;
        if (FlushE) begin
            ctrl_d     = '0;
            alu_ctrl_d = '0;
            flag_wr_d  = '0;
            cond_d     = '0;
            rd1_d      = '0;
            rd2_d      = '0;
            imm_d      = '0;
            wa3_d      = '0;
            valid_d    = 1'b0;
        end else if (!StallE) begin
            ctrl_d     = {PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, ALUSelD};
            alu_ctrl_d = ALUControlD;
            flag_wr_d  = FlagWriteD;
            cond_d     = CondD;
            rd1_d      = RD1D;
            rd2_d      = RD2D;
            imm_d      = ExtImmD;
            wa3_d      = WA3D;
            valid_d    = 1'b1;
        end
    end

    // Flush does not gate this: the instruction leaving E still commits its flags.
    always_comb begin
        flags_d = flags_q;
        if (flag_upd && flag_wr_q[1]) flags_d[3:2] = ALUFlags[3:2];
        if (flag_upd && flag_wr_q[0]) flags_d[1:0] = ALUFlags[1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q     <= '0;
            alu_ctrl_q <= '0;
            flag_wr_q  <= '0;
            cond_q     <= '0;
            rd1_q      <= '0;
            rd2_q      <= '0;
            imm_q      <= '0;
            wa3_q      <= '0;
            valid_q    <= 1'b0;
            flags_q    <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            alu_ctrl_q <= alu_ctrl_d;
            flag_wr_q  <= flag_wr_d;
            cond_q     <= cond_d;
            rd1_q      <= rd1_d;
            rd2_q      <= rd2_d;
            imm_q      <= imm_d;
            wa3_q      <= wa3_d;
            valid_q    <= valid_d;
            flags_q    <= flags_d;
        end
    end

    assign PCSrcE      = ctrl_q[6] && cond_ex;
    assign RegWriteE   = ctrl_q[5] && cond_ex;
    assign MemtoRegE   = ctrl_q[4];
    assign MemWriteE   = ctrl_q[3] && cond_ex;
    assign BranchE     = ctrl_q[2] && cond_ex;
    assign ALUSrcE     = ctrl_q[1];
    assign ALUSelE     = ctrl_q[0];
    assign ALUControlE = alu_ctrl_q;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign ExtImmE     = imm_q;
    assign WA3E        = wa3_q;
    assign CondExE     = cond_ex;
    assign FlagsE      = flags_q;
    assign ValidE      = valid_q;

endmodule

// File: tb/tb_id_ex_cond_stage.sv
// Directed self-checking bench for id_ex_cond_stage. Expected values are hand-derived;
// the condition sweep uses an independent base-condition/invert model.
module tb_id_ex_cond_stage;

`ifdef COND_EXEC_EN
    localparam bit CondEn = 1'b1;
`else
    localparam bit CondEn = 1'b0;
`endif

    logic        clk, rst, StallE, FlushE;
    logic        PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, ALUSelD;
    logic [2:0]  ALUControlD;
    logic [1:0]  FlagWriteD;
    logic [3:0]  CondD, WA3D, ALUFlags;
    logic [31:0] RD1D, RD2D, ExtImmD;
    logic [2:0]  ALUControlE;
    logic        ALUSelE, ALUSrcE, MemtoRegE;
    logic [31:0] RD1E, RD2E, ExtImmE;
    logic [3:0]  WA3E, FlagsE;
    logic        PCSrcE, RegWriteE, MemWriteE, BranchE, CondExE, ValidE;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_cond_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
        .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD),
        .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUSelD(ALUSelD),
        .ALUControlD(ALUControlD), .FlagWriteD(FlagWriteD), .CondD(CondD),
        .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD), .WA3D(WA3D), .ALUFlags(ALUFlags),
        .ALUControlE(ALUControlE), .ALUSelE(ALUSelE), .ALUSrcE(ALUSrcE),
        .MemtoRegE(MemtoRegE), .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .WA3E(WA3E),
        .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .CondExE(CondExE), .FlagsE(FlagsE), .ValidE(ValidE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Plain AL instruction with no side effects.
    task automatic nop();
        {PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, ALUSelD} = '0;
        ALUControlD = '0;
        FlagWriteD  = '0;
        CondD       = 4'b1110;
        RD1D        = '0;
        RD2D        = '0;
        ExtImmD     = '0;
        WA3D        = '0;
    endtask

    // Base condition from cond[3:1]; odd codes invert it, 1111 never executes.
    function automatic bit cond_model(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'b1111) return 1'b0;
        return c[0] ? ~base : base;
    endfunction

    initial begin
        rst = 1'b1;
        StallE = 1'b0;
        FlushE = 1'b0;
        {PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, ALUSelD} = '1;
        ALUControlD = '1;
        FlagWriteD  = '1;
        CondD       = '1;
        RD1D        = '1;
        RD2D        = '1;
        ExtImmD     = '1;
        WA3D        = '1;
        ALUFlags    = '1;
        #2 rst = 1'b0;
        step();
        step();
        check_eq("rst_valid",    ValidE,    0);
        check_eq("rst_regwrite", RegWriteE, 0);
        check_eq("rst_pcsrc",    PCSrcE,    0);
        check_eq("rst_memwrite", MemWriteE, 0);
        check_eq("rst_branch",   BranchE,   0);
        check_eq("rst_condex",   CondExE,   0);
        check_eq("rst_flags",    FlagsE,    0);
        check_eq("rst_aluctrl",  ALUControlE, 0);
        check_eq("rst_rd1",      RD1E,      0);
        check_eq("rst_wa3",      WA3E,      0);

        // First AL instruction after reset release.
        nop();
        RegWriteD   = 1'b1;
        RD1D        = 32'h1234_5678;
        WA3D        = 4'd3;
        ALUControlD = 3'd5;
        ALUFlags    = 4'b0000;
        rst = 1'b1;
        step();
        check_eq("al_valid",    ValidE,      1);
        check_eq("al_regwrite", RegWriteE,   1);
        check_eq("al_condex",   CondExE,     1);
        check_eq("al_rd1",      RD1E,        32'h1234_5678);
        check_eq("al_wa3",      WA3E,        3);
        check_eq("al_aluctrl",  ALUControlE, 5);

        // Flag producer then EQ consumer, then NE consumer.
        nop();
        FlagWriteD = 2'b11;
        step();
        ALUFlags = 4'b0100;
        nop();
        RegWriteD = 1'b1;
        CondD     = 4'b0000;
        step();
        check_eq("eq_flags",    FlagsE,    4'b0100);
        check_eq("eq_regwrite", RegWriteE, 1);
        check_eq("eq_condex",   CondExE,   1);
        nop();
        RegWriteD = 1'b1;
        MemWriteD = 1'b1;
        CondD     = 4'b0001;
        step();
        check_eq("ne_regwrite", RegWriteE, CondEn ? 0 : 1);
        check_eq("ne_memwrite", MemWriteE, CondEn ? 0 : 1);
        check_eq("ne_flags",    FlagsE,    4'b0100);

        // Partial flag write: only N,Z updated.
        nop();
        FlagWriteD = 2'b11;
        step();
        ALUFlags = 4'b1111;
        nop();
        FlagWriteD = 2'b10;
        step();
        check_eq("pw_flags_all", FlagsE, 4'b1111);
        ALUFlags = 4'b0000;
        nop();
        step();
        check_eq("pw_flags_nz", FlagsE, 4'b0011);

        // Stall holds the slot and defers the flag write to a single update.
        nop();
        FlagWriteD = 2'b11;
        WA3D       = 4'd5;
        RD1D       = 32'hCAFE_0001;
        step();
        ALUFlags = 4'b1000;
        StallE   = 1'b1;
        nop();
        WA3D = 4'd9;
        RD1D = 32'h0000_DEAD;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("stall%0d_wa3", i),   WA3E,   5);
            check_eq($sformatf("stall%0d_rd1", i),   RD1E,   32'hCAFE_0001);
            check_eq($sformatf("stall%0d_flags", i), FlagsE, 4'b0011);
            check_eq($sformatf("stall%0d_valid", i), ValidE, 1);
        end
        StallE = 1'b0;
        nop();
        step();
        check_eq("stall_rel_flags", FlagsE, 4'b1000);
        check_eq("stall_rel_wa3",   WA3E,   0);
        ALUFlags = 4'b0101;
        step();
        check_eq("stall_once_flags", FlagsE, 4'b1000);

        // Flush beats stall.
        nop();
        RegWriteD = 1'b1;
        MemWriteD = 1'b1;
        PCSrcD    = 1'b1;
        BranchD   = 1'b1;
        RD1D      = 32'h55;
        WA3D      = 4'd7;
        step();
        check_eq("pre_fl_pcsrc",  PCSrcE,  1);
        check_eq("pre_fl_branch", BranchE, 1);
        FlushE = 1'b1;
        StallE = 1'b1;
        step();
        check_eq("fl_valid",    ValidE,    0);
        check_eq("fl_regwrite", RegWriteE, 0);
        check_eq("fl_memwrite", MemWriteE, 0);
        check_eq("fl_pcsrc",    PCSrcE,    0);
        check_eq("fl_branch",   BranchE,   0);
        check_eq("fl_condex",   CondExE,   0);
        check_eq("fl_rd1",      RD1E,      0);
        check_eq("fl_wa3",      WA3E,      0);
        FlushE = 1'b0;
        StallE = 1'b0;

        // Flush does not block the leaving instruction's flag write.
        nop();
        FlagWriteD = 2'b11;
        step();
        ALUFlags = 4'b0110;
        FlushE   = 1'b1;
        step();
        FlushE = 1'b0;
        check_eq("flw_flags", FlagsE, 4'b0110);
        check_eq("flw_valid", ValidE, 0);

        // Asynchronous reset between edges.
        nop();
        RegWriteD = 1'b1;
        step();
        check_eq("ar_pre_valid", ValidE, 1);
        #3 rst = 1'b0;
        #1;
        check_eq("ar_valid",    ValidE,    0);
        check_eq("ar_regwrite", RegWriteE, 0);
        check_eq("ar_flags",    FlagsE,    0);
        #2 rst = 1'b1;

        // Condition sweep: each flag pattern set by an AL producer, then 16 consumers.
        for (int f = 0; f < 16; f++) begin
            nop();
            FlagWriteD = 2'b11;
            step();
            ALUFlags = f[3:0];
            for (int c = 0; c < 16; c++) begin
                nop();
                RegWriteD = 1'b1;
                CondD     = c[3:0];
                step();
                check_eq($sformatf("cond%0h_flags%0h", c, f), CondExE,
                         CondEn ? cond_model(c[3:0], f[3:0]) : 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
